// File: rtl/ps2_keymap_fifo.sv
// PS/2 set-2 byte parser with JIS-106 keymap feeding a show-ahead character FIFO.
// Optional build macro KEYMAP_UNKNOWN_PUSH_EN: unmapped make codes push UNKNOWN_CHAR.
//
// state     | meaning
// S_IDLE    | waiting for a make code or a prefix byte
// S_BRK     | F0 seen, next byte is a released key
// S_EXT     | E0 seen, next byte is an extended key or F0
// S_EXT_BRK | E0 F0 seen, next byte is a released extended key
// S_PAUSE   | E1 seen, swallowing the rest of the pause sequence
module ps2_keymap_fifo #(
    parameter int         FIFO_DEPTH   = 8,
    parameter int         CNT_W        = $clog2(FIFO_DEPTH) + 1,
    parameter logic [7:0] UNKNOWN_CHAR = 8'hFF
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_scancode,
    input  logic             i_valid,
    input  logic             i_ready,
    input  logic             i_ovf_clr,
    output logic [7:0]       o_ascii,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_overflow,
    output logic             o_shift,
    output logic             o_capslock
);
    localparam int         PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [2:0] SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_PAUSE} state_t;

    state_t     state, state_nxt;
    logic [2:0] skip_cnt, skip_nxt;
    logic       lshift, lshift_nxt, rshift, rshift_nxt;
    logic       caps, caps_nxt, caps_held, caps_held_nxt;
    logic       push;
    logic [7:0] push_data;
    logic [8:0] map;

    // Returns {mapped, character}; shift and camel come from the pre-byte modifier state.
    function automatic logic [8:0] keymap(input logic [7:0] code, input logic shift,
                                          input logic camel);
        logic [7:0] lower;
        logic [8:0] res;
        res = 9'h000;
        case (code)
            8'h1C: lower = 8'h61;  8'h32: lower = 8'h62;  8'h21: lower = 8'h63;
            8'h23: lower = 8'h64;  8'h24: lower = 8'h65;  8'h2B: lower = 8'h66;
            8'h34: lower = 8'h67;  8'h33: lower = 8'h68;  8'h43: lower = 8'h69;
            8'h3B: lower = 8'h6A;  8'h42: lower = 8'h6B;  8'h4B: lower = 8'h6C;
            8'h3A: lower = 8'h6D;  8'h31: lower = 8'h6E;  8'h44: lower = 8'h6F;
            8'h4D: lower = 8'h70;  8'h15: lower = 8'h71;  8'h2D: lower = 8'h72;
            8'h1B: lower = 8'h73;  8'h2C: lower = 8'h74;  8'h3C: lower = 8'h75;
            8'h2A: lower = 8'h76;  8'h1D: lower = 8'h77;  8'h22: lower = 8'h78;
            8'h35: lower = 8'h79;  8'h1A: lower = 8'h7A;
            default: lower = 8'h00;
        endcase
        if (lower != 8'h00) begin
            res = {1'b1, camel ? lower - 8'h20 : lower};
        end else begin
            case (code)
                8'h16: res = {1'b1, shift ? 8'h21 : 8'h31};
                8'h1E: res = {1'b1, shift ? 8'h22 : 8'h32};
                8'h26: res = {1'b1, shift ? 8'h23 : 8'h33};
                8'h25: res = {1'b1, shift ? 8'h24 : 8'h34};
                8'h2E: res = {1'b1, shift ? 8'h25 : 8'h35};
                8'h36: res = {1'b1, shift ? 8'h26 : 8'h36};
                8'h3D: res = {1'b1, shift ? 8'h27 : 8'h37};
                8'h3E: res = {1'b1, shift ? 8'h28 : 8'h38};
                8'h46: res = {1'b1, shift ? 8'h29 : 8'h39};
                8'h45: res = {1'b1, 8'h30};
                8'h4E: res = {1'b1, shift ? 8'h3D : 8'h2D};
                8'h55: res = {1'b1, shift ? 8'h7E : 8'h5E};
                8'h6A: res = {1'b1, shift ? 8'h7C : 8'h5C};
                8'h54: res = {1'b1, shift ? 8'h60 : 8'h40};
                8'h5B: res = {1'b1, shift ? 8'h7B : 8'h5B};
                8'h4C: res = {1'b1, shift ? 8'h2B : 8'h3B};
                8'h52: res = {1'b1, shift ? 8'h2A : 8'h3A};
                8'h5D: res = {1'b1, shift ? 8'h7D : 8'h5D};
                8'h41: res = {1'b1, shift ? 8'h3C : 8'h2C};
                8'h49: res = {1'b1, shift ? 8'h3E : 8'h2E};
                8'h4A: res = {1'b1, shift ? 8'h3F : 8'h2F};
                8'h51: res = {1'b1, 8'h5F};
                8'h66: res = {1'b1, 8'h08};
                8'h5A: res = {1'b1, 8'h0D};
                8'h29: res = {1'b1, 8'h20};
                8'h76: res = {1'b1, 8'h1B};
                default: res = 9'h000;
            endcase
        end
        return res;
    endfunction

    assign o_shift    = lshift | rshift;
    assign o_capslock = caps;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            skip_cnt  <= 3'd0;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
        end else begin
            state     <= state_nxt;
            skip_cnt  <= skip_nxt;
            lshift    <= lshift_nxt;
            rshift    <= rshift_nxt;
            caps      <= caps_nxt;
            caps_held <= caps_held_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        skip_nxt      = skip_cnt;
        lshift_nxt    = lshift;
        rshift_nxt    = rshift;
        caps_nxt      = caps;
        caps_held_nxt = caps_held;
        push          = 1'b0;
        push_data     = 8'h00;
        map           = keymap(i_scancode, o_shift, o_shift ^ caps);
        if (i_valid) begin
            case (state)
                S_IDLE: begin
                    case (i_scancode)
                        8'hF0: state_nxt = S_BRK;
                        8'hE0: state_nxt = S_EXT;
                        8'hE1: begin
                            state_nxt = S_PAUSE;
                            skip_nxt  = SKIP_LEN;
                        end
                        8'h12: lshift_nxt = 1'b1;
                        8'h59: rshift_nxt = 1'b1;
                        8'h58: begin
                            // Typematic repeats of capslock must not re-toggle.
                            if (!caps_held) caps_nxt = ~caps;
                            caps_held_nxt = 1'b1;
                        end
                        8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: ;
                        default: begin
                            push_data = map[8] ? map[7:0] : UNKNOWN_CHAR;
`ifdef KEYMAP_UNKNOWN_PUSH_EN
                            push      = 1'b1;
`else
                            push      = map[8];
`endif
                        end
                    endcase
                end
                S_BRK: begin
                    state_nxt = S_IDLE;
                    case (i_scancode)
                        8'h12:   lshift_nxt    = 1'b0;
                        8'h59:   rshift_nxt    = 1'b0;
                        8'h58:   caps_held_nxt = 1'b0;
                        default: ;
                    endcase
                end
                S_EXT: begin
                    state_nxt = S_IDLE;
                    case (i_scancode)
                        8'hF0: state_nxt = S_EXT_BRK;
                        8'h5A: begin
                            push      = 1'b1;
                            push_data = 8'h0D;
                        end
                        8'h4A: begin
                            push      = 1'b1;
                            push_data = 8'h2F;
                        end
                        default: ;
                    endcase
                end
                S_EXT_BRK: state_nxt = S_IDLE;
                S_PAUSE: begin
                    skip_nxt = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop, wr_ok, drop;

    assign o_count = count;
    assign o_valid = (count != '0);
    assign o_full  = (count == CNT_W'(FIFO_DEPTH));
    assign o_ascii = o_valid ? mem[rd_ptr] : 8'h00;
    assign pop     = i_ready && o_valid;
    assign wr_ok   = push && (!o_full || pop);
    assign drop    = push && o_full && !pop;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)           o_overflow <= 1'b1;
            else if (i_ovf_clr) o_overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_keymap_fifo.sv
// Self-checking bench for ps2_keymap_fifo: directed vector table, hand sequences and a
// randomized run checked against a token-level keyboard/FIFO model.
module tb_ps2_keymap_fifo;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [7:0]    i_scancode = 8'h00;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic          i_ovf_clr = 1'b0;
    logic [7:0]    o_ascii;
    logic          o_valid;
    logic [CW-1:0] o_count;
    logic          o_full;
    logic          o_overflow;
    logic          o_shift;
    logic          o_capslock;

    int errors = 0;
    int checks = 0;

    ps2_keymap_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_scancode(i_scancode), .i_valid(i_valid),
        .i_ready(i_ready), .i_ovf_clr(i_ovf_clr), .o_ascii(o_ascii), .o_valid(o_valid),
        .o_count(o_count), .o_full(o_full), .o_overflow(o_overflow), .o_shift(o_shift),
        .o_capslock(o_capslock)
    );

    always #5 clk = ~clk;

    // Keymap tables built from the character chart.
    logic [7:0] norm_tbl [256];
    logic [7:0] shft_tbl [256];
    bit         is_letter [256];
    bit         is_mapped [256];

    // Model state: pending multi-byte token, modifiers, character queue.
    logic [7:0] pend [$];
    logic [7:0] fq [$];
    bit         m_ls, m_rs, m_caps, m_held, m_ovf;

    task automatic build_tables();
        logic [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dc [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        logic [23:0] sym [17] = '{24'h4E2D3D, 24'h555E7E, 24'h6A5C7C, 24'h544060, 24'h5B5B7B,
                                  24'h4C3B2B, 24'h523A2A, 24'h5D5D7D, 24'h412C3C, 24'h492E3E,
                                  24'h4A2F3F, 24'h455F5F, 24'h51_5F_5F, 24'h660808,
                                  24'h5A0D0D, 24'h292020, 24'h761B1B};
        for (int i = 0; i < 256; i++) begin
            norm_tbl[i] = 8'h00; shft_tbl[i] = 8'h00; is_letter[i] = 0; is_mapped[i] = 0;
        end
        for (int i = 0; i < 26; i++) begin
            norm_tbl[lc[i]] = 8'h61 + 8'(i); is_letter[lc[i]] = 1; is_mapped[lc[i]] = 1;
        end
        for (int i = 0; i < 9; i++) begin
            norm_tbl[dc[i]] = 8'h31 + 8'(i); shft_tbl[dc[i]] = 8'h21 + 8'(i);
            is_mapped[dc[i]] = 1;
        end
        sym[11] = 24'h453030;
        for (int i = 0; i < 17; i++) begin
            norm_tbl[sym[i][23:16]] = sym[i][15:8];
            shft_tbl[sym[i][23:16]] = sym[i][7:0];
            is_mapped[sym[i][23:16]] = 1;
        end
    endtask

    task automatic model_reset();
        pend.delete(); fq.delete();
        m_ls = 0; m_rs = 0; m_caps = 0; m_held = 0; m_ovf = 0;
    endtask

    // Collects bytes into whole messages, then applies the message's effect.
    task automatic model_byte(input logic [7:0] b, output bit push, output logic [7:0] ch);
        bit sh;
        push = 0; ch = 8'h00;
        pend.push_back(b);
        case (pend[0])
            8'hE1: if (pend.size() == 8) pend.delete();
            8'hE0: begin
                if (pend.size() == 2 && pend[1] != 8'hF0) begin
                    if (pend[1] == 8'h5A) begin push = 1; ch = 8'h0D; end
                    if (pend[1] == 8'h4A) begin push = 1; ch = 8'h2F; end
                    pend.delete();
                end else if (pend.size() == 3) pend.delete();
            end
            8'hF0: begin
                if (pend.size() == 2) begin
                    if (pend[1] == 8'h12) m_ls = 0;
                    if (pend[1] == 8'h59) m_rs = 0;
                    if (pend[1] == 8'h58) m_held = 0;
                    pend.delete();
                end
            end
            default: begin
                pend.delete();
                sh = m_ls | m_rs;
                if (b == 8'h12) m_ls = 1;
                else if (b == 8'h59) m_rs = 1;
                else if (b == 8'h58) begin
                    if (!m_held) m_caps = !m_caps;
                    m_held = 1;
                end else if (b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hFF) begin
                end else if (is_mapped[b]) begin
                    push = 1;
                    if (is_letter[b]) ch = (sh ^ m_caps) ? norm_tbl[b] - 8'h20 : norm_tbl[b];
                    else ch = sh ? shft_tbl[b] : norm_tbl[b];
                end else begin
`ifdef KEYMAP_UNKNOWN_PUSH_EN
                    push = 1; ch = 8'hFF;
`endif
                end
            end
        endcase
    endtask

    task automatic model_cycle(input bit v, input logic [7:0] c, input bit r, input bit clr);
        bit push, pop;
        logic [7:0] ch;
        pop = r && fq.size() > 0;
        push = 0; ch = 8'h00;
        if (v) model_byte(c, push, ch);
        if (pop) void'(fq.pop_front());
        if (clr) m_ovf = 0;
        if (push) begin
            if (fq.size() < DEPTH) fq.push_back(ch);
            else m_ovf = 1;
        end
    endtask

    task automatic check_outputs(input string nm);
        logic [16:0] act, exp;
        act = {o_valid, o_full, o_overflow, o_shift, o_capslock, 4'(o_count), o_ascii};
        exp = {fq.size() > 0, fq.size() == DEPTH, m_ovf, m_ls | m_rs, m_caps,
               4'(fq.size()), (fq.size() > 0) ? fq[0] : 8'h00};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {valid,full,ovf,shift,caps,count,ascii} got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input bit v, input logic [7:0] c, input bit r,
                        input bit clr);
        i_valid = v; i_scancode = c; i_ready = r; i_ovf_clr = clr;
        model_cycle(v, c, r, clr);
        @(posedge clk);
        @(negedge clk);
        check_outputs(nm);
    endtask

    task automatic press(input logic [7:0] c);
        step("press", 1'b1, c, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit         v;
        logic [7:0] c;
        bit         r;
        int         e_count;
        logic [7:0] e_ascii;
        bit         e_shift;
        bit         e_caps;
    } vec_t;
    vec_t vecs [$];

    function automatic vec_t av(bit v, logic [7:0] c, bit r, int n, logic [7:0] a, bit s, bit k);
        vec_t t;
        t.v = v; t.c = c; t.r = r; t.e_count = n; t.e_ascii = a; t.e_shift = s; t.e_caps = k;
        return t;
    endfunction

    logic [7:0] pool [24] = '{8'h1C, 8'h32, 8'h1A, 8'h16, 8'h45, 8'h4E, 8'h55, 8'h4A, 8'h5A,
                              8'h29, 8'h12, 8'h59, 8'h58, 8'hF0, 8'hE0, 8'hE1, 8'h0E, 8'h14,
                              8'hAA, 8'h00, 8'h76, 8'h66, 8'h51, 8'h6A};

    initial begin
        build_tables();
        model_reset();

        // basic make/break, pop
        vecs.push_back(av(1, 8'h1C, 0, 1, 8'h61, 0, 0));
        vecs.push_back(av(1, 8'hF0, 0, 1, 8'h61, 0, 0));
        vecs.push_back(av(1, 8'h1C, 0, 1, 8'h61, 0, 0));
        vecs.push_back(av(0, 8'h00, 1, 0, 8'h00, 0, 0));
        // shift
        vecs.push_back(av(1, 8'h12, 0, 0, 8'h00, 1, 0));
        vecs.push_back(av(1, 8'h1C, 0, 1, 8'h41, 1, 0));
        vecs.push_back(av(1, 8'hF0, 0, 1, 8'h41, 1, 0));
        vecs.push_back(av(1, 8'h1C, 0, 1, 8'h41, 1, 0));
        vecs.push_back(av(1, 8'hF0, 0, 1, 8'h41, 1, 0));
        vecs.push_back(av(1, 8'h12, 0, 1, 8'h41, 0, 0));
        vecs.push_back(av(1, 8'h1C, 0, 2, 8'h41, 0, 0));
        vecs.push_back(av(0, 8'h00, 1, 1, 8'h61, 0, 0));
        vecs.push_back(av(0, 8'h00, 1, 0, 8'h00, 0, 0));
        // capslock with typematic repeats
        vecs.push_back(av(1, 8'h58, 0, 0, 8'h00, 0, 1));
        vecs.push_back(av(1, 8'h58, 0, 0, 8'h00, 0, 1));
        vecs.push_back(av(1, 8'h58, 0, 0, 8'h00, 0, 1));
        vecs.push_back(av(1, 8'hF0, 0, 0, 8'h00, 0, 1));
        vecs.push_back(av(1, 8'h58, 0, 0, 8'h00, 0, 1));
        vecs.push_back(av(1, 8'h1C, 0, 1, 8'h41, 0, 1));
        vecs.push_back(av(0, 8'h00, 1, 0, 8'h00, 0, 1));
        vecs.push_back(av(1, 8'h58, 0, 0, 8'h00, 0, 0));
        vecs.push_back(av(1, 8'hF0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(av(1, 8'h58, 0, 0, 8'h00, 0, 0));
        // extended keys, fake shift
        vecs.push_back(av(1, 8'hE0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(av(1, 8'h5A, 0, 1, 8'h0D, 0, 0));
        vecs.push_back(av(1, 8'hE0, 0, 1, 8'h0D, 0, 0));
        vecs.push_back(av(1, 8'h12, 0, 1, 8'h0D, 0, 0));
        vecs.push_back(av(1, 8'h1C, 0, 2, 8'h0D, 0, 0));
        vecs.push_back(av(0, 8'h00, 1, 1, 8'h61, 0, 0));
        vecs.push_back(av(0, 8'h00, 1, 0, 8'h00, 0, 0));
        // pause sequence swallowed
        vecs.push_back(av(1, 8'hE1, 0, 0, 8'h00, 0, 0));
        vecs.push_back(av(1, 8'h14, 0, 0, 8'h00, 0, 0));
        vecs.push_back(av(1, 8'h77, 0, 0, 8'h00, 0, 0));
        vecs.push_back(av(1, 8'hE1, 0, 0, 8'h00, 0, 0));
        vecs.push_back(av(1, 8'hF0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(av(1, 8'h14, 0, 0, 8'h00, 0, 0));
        vecs.push_back(av(1, 8'hF0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(av(1, 8'h77, 0, 0, 8'h00, 0, 0));
        vecs.push_back(av(1, 8'h29, 0, 1, 8'h20, 0, 0));
        vecs.push_back(av(0, 8'h00, 1, 0, 8'h00, 0, 0));
        // digits with right shift
        vecs.push_back(av(1, 8'h16, 0, 1, 8'h31, 0, 0));
        vecs.push_back(av(1, 8'hF0, 0, 1, 8'h31, 0, 0));
        vecs.push_back(av(1, 8'h16, 0, 1, 8'h31, 0, 0));
        vecs.push_back(av(1, 8'h59, 0, 1, 8'h31, 1, 0));
        vecs.push_back(av(1, 8'h16, 0, 2, 8'h31, 1, 0));
        vecs.push_back(av(1, 8'hF0, 0, 2, 8'h31, 1, 0));
        vecs.push_back(av(1, 8'h59, 0, 2, 8'h31, 0, 0));
        vecs.push_back(av(0, 8'h00, 1, 1, 8'h21, 0, 0));
        vecs.push_back(av(0, 8'h00, 1, 0, 8'h00, 0, 0));

        // reset state
        repeat (2) @(negedge clk);
        check_outputs("reset");
        i_rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            step("vec_model", vecs[i].v, vecs[i].c, vecs[i].r, 1'b0);
            checks++;
            if ({4'(o_count), o_valid, o_ascii, o_shift, o_capslock} !==
                {4'(vecs[i].e_count), vecs[i].e_count != 0, vecs[i].e_ascii,
                 vecs[i].e_shift, vecs[i].e_caps}) begin
                errors++;
                $display("FAIL vec[%0d]: count=%0d valid=%b ascii=%h shift=%b caps=%b, want count=%0d ascii=%h shift=%b caps=%b",
                         i, o_count, o_valid, o_ascii, o_shift, o_capslock,
                         vecs[i].e_count, vecs[i].e_ascii, vecs[i].e_shift, vecs[i].e_caps);
            end
        end

        // overflow: DEPTH+1 pushes with no pop, then push while popping when full
        for (int i = 0; i < DEPTH + 1; i++) press(8'h29);
        checks++;
        if (!(o_full && o_count == CW'(DEPTH) && o_overflow)) begin
            errors++;
            $display("FAIL overflow_set: full=%b count=%0d ovf=%b, want 1 %0d 1", o_full, o_count, o_overflow, DEPTH);
        end
        step("full_push_pop", 1'b1, 8'h1C, 1'b1, 1'b0);
        checks++;
        if (o_count != CW'(DEPTH) || !o_full) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d full=%b, want %0d 1", o_count, o_full, DEPTH);
        end
        step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: ovf=%b want 0", o_overflow);
        end
        step("clr_vs_drop", 1'b1, 8'h29, 1'b0, 1'b1);
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_drop: ovf=%b want 1", o_overflow);
        end
        step("ovf_clr2", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // unknown make code
        press(8'h0E);
        checks++;
`ifdef KEYMAP_UNKNOWN_PUSH_EN
        if (o_count != CW'(1) || o_ascii != 8'hFF) begin
`else
        if (o_count != CW'(0)) begin
`endif
            errors++;
            $display("FAIL unknown_0e: count=%0d ascii=%h", o_count, o_ascii);
        end
        step("drain_unk", 1'b0, 8'h00, 1'b1, 1'b0);

        // reset in the middle of a sequence, asserted away from the clock edge
        press(8'h12);
        press(8'hF0);
        i_valid = 1'b0; i_ready = 1'b0; i_ovf_clr = 1'b0;
        #2 i_rst_n = 1'b0;
        model_reset();
        #1 check_outputs("async_reset");
        @(negedge clk);
        i_rst_n = 1'b1;
        press(8'h1C);
        checks++;
        if (o_count != CW'(1) || o_ascii != 8'h61 || o_shift) begin
            errors++;
            $display("FAIL post_reset: count=%0d ascii=%h shift=%b, want 1 61 0", o_count, o_ascii, o_shift);
        end
        step("post_reset_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            bit v, r, c;
            v = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 9) < 3);
            c = ($urandom_range(0, 19) == 0);
            step("random", v, pool[$urandom_range(0, 23)], r, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
